// File: rtl/panel_load_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// panel_load_sequencer_pkg : shared types for the front-panel image loader
// Rev 1.0
// ============================================================================
package panel_load_sequencer_pkg;

   localparam int unsigned ADDR_W = 12;
   localparam int unsigned SW_W   = ADDR_W + 1;

   typedef enum logic [3:0] {
      IDLE, INIT_LPC, FETCH, WORD_LPC, GAP, DEPOSIT, FINAL_LPC, RUN, DONE
   } ldr_state_t;

   typedef enum logic [1:0] {BTN_NONE, BTN_LPC, BTN_DEP} panel_btn_t;

   typedef enum logic [1:0] {OP_IDLE, OP_SETUP, OP_PRESS, OP_RELEASE} op_phase_t;

   // Deposit auto-increments PC modulo 4096, so 7777 -> 0000 is sequential.
   function automatic logic is_sequential(input logic [ADDR_W-1:0] prev,
                                          input logic [ADDR_W-1:0] cur);
      logic [ADDR_W-1:0] nxt;
      nxt = prev + 1'b1;
      return cur == nxt;
   endfunction

endpackage
`default_nettype wire

// File: rtl/panel_load_sequencer_op_gen.sv
`default_nettype none
// ============================================================================
// panel_op_gen : one SETUP / PRESS / RELEASE front-panel button operation
// Rev 1.0
// ============================================================================
module panel_op_gen
   import panel_load_sequencer_pkg::*;
#(
   parameter int unsigned SETUP_CYC = 10,
   parameter int unsigned PULSE_CYC = 10
) (
   input  logic              clock_i,
   input  logic              resetN_i,
   input  logic              go_i,
   input  panel_btn_t        btn_i,
   input  logic [ADDR_W-1:0] value_i,
   output logic [ADDR_W-1:0] sw_val_o,
   output logic              btnl_o,
   output logic              btnd_o,
   output logic              op_done_o
);

   localparam int unsigned MAX_CYC = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);

   op_phase_t         phase_q;
   panel_btn_t        btn_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [ADDR_W-1:0] sw_val_q;
   logic              btnl_q;
   logic              btnd_q;
   logic              op_done_q;

   // The value register is only rewritten on go, so it stays on the switches
   // through RELEASE and until the next operation begins.
   always_ff @(posedge clock_i or negedge resetN_i) begin
      if (!resetN_i) begin
         phase_q   <= OP_IDLE;
         btn_q     <= BTN_NONE;
         cnt_q     <= '0;
         sw_val_q  <= '0;
         btnl_q    <= 1'b0;
         btnd_q    <= 1'b0;
         op_done_q <= 1'b0;
      end else begin
         op_done_q <= 1'b0;
         unique case (phase_q)
            OP_IDLE: begin
               if (go_i) begin
                  sw_val_q <= value_i;
                  btn_q    <= btn_i;
                  cnt_q    <= SETUP_LOAD;
                  phase_q  <= OP_SETUP;
               end
            end
            OP_SETUP: begin
               if (cnt_q == '0) begin
                  btnl_q  <= (btn_q == BTN_LPC);
                  btnd_q  <= (btn_q == BTN_DEP);
                  cnt_q   <= PULSE_LOAD;
                  phase_q <= OP_PRESS;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            OP_PRESS: begin
               if (cnt_q == '0) begin
                  btnl_q  <= 1'b0;
                  btnd_q  <= 1'b0;
                  cnt_q   <= SETUP_LOAD;
                  phase_q <= OP_RELEASE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            OP_RELEASE: begin
               if (cnt_q == '0) begin
                  op_done_q <= 1'b1;
                  phase_q   <= OP_IDLE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: phase_q <= OP_IDLE;
         endcase
      end
   end

   assign sw_val_o  = sw_val_q;
   assign btnl_o    = btnl_q;
   assign btnd_o    = btnd_q;
   assign op_done_o = op_done_q;

endmodule
`default_nettype wire

// File: rtl/panel_load_sequencer.sv
`default_nettype none
// ============================================================================
// panel_load_sequencer : loads an image into the PDP-8 via front-panel
// Load-PC/Deposit operations, reloads PC and starts the CPU. Rev 1.0
// ============================================================================
module panel_load_sequencer
   import panel_load_sequencer_pkg::*;
#(
   parameter int unsigned       SETUP_CYC = 10,
   parameter int unsigned       PULSE_CYC = 10,
   parameter int unsigned       GAP_CYC   = 30,
   parameter logic [ADDR_W-1:0] START_PC  = 12'o0200,
   parameter bit                SKIP_SEQ  = 1'b0
) (
   input  logic              clock_i,
   input  logic              resetN_i,
   input  logic              start_i,
   input  logic              word_valid_i,
   output logic              word_ready_o,
   input  logic [ADDR_W-1:0] word_addr_i,
   input  logic [ADDR_W-1:0] word_data_i,
   input  logic              word_last_i,
   input  logic              run_led_i,
   output logic [SW_W-1:0]   sw_o,
   output logic              btnl_o,
   output logic              btnd_o,
   output logic              busy_o,
   output logic              halted_o
);

   localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);

   ldr_state_t        state_q;
   logic              go_q;
   panel_btn_t        btn_q;
   logic [ADDR_W-1:0] value_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] data_q;
   logic              last_q;
   logic [ADDR_W-1:0] prev_q;
   logic              hist_q;
   logic [GAP_W-1:0]  gap_q;
   logic              seen_q;
   logic              run_q;
   logic              ready_q;
   logic              busy_q;
   logic              halted_q;

   logic [ADDR_W-1:0] sw_val;
   logic              op_done;

   panel_op_gen #(
      .SETUP_CYC (SETUP_CYC),
      .PULSE_CYC (PULSE_CYC)
   ) u_op_gen (
      .clock_i   (clock_i),
      .resetN_i  (resetN_i),
      .go_i      (go_q),
      .btn_i     (btn_q),
      .value_i   (value_q),
      .sw_val_o  (sw_val),
      .btnl_o    (btnl_o),
      .btnd_o    (btnd_o),
      .op_done_o (op_done)
   );

   always_ff @(posedge clock_i or negedge resetN_i) begin
      if (!resetN_i) begin
         state_q  <= IDLE;
         go_q     <= 1'b0;
         btn_q    <= BTN_NONE;
         value_q  <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         last_q   <= 1'b0;
         prev_q   <= '0;
         hist_q   <= 1'b0;
         gap_q    <= '0;
         seen_q   <= 1'b0;
         run_q    <= 1'b0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         go_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start_i) begin
                  // A fresh load starts from START_PC, so old history is void.
                  hist_q   <= 1'b0;
                  busy_q   <= 1'b1;
                  halted_q <= 1'b0;
                  go_q     <= 1'b1;
                  btn_q    <= BTN_LPC;
                  value_q  <= START_PC;
                  state_q  <= INIT_LPC;
               end
            end
            INIT_LPC: begin
               if (op_done) begin
                  ready_q <= 1'b1;
                  state_q <= FETCH;
               end
            end
            FETCH: begin
               if (word_valid_i && ready_q) begin
                  ready_q <= 1'b0;
                  addr_q  <= word_addr_i;
                  data_q  <= word_data_i;
                  last_q  <= word_last_i;
                  go_q    <= 1'b1;
                  if (SKIP_SEQ && hist_q && is_sequential(prev_q, word_addr_i)) begin
                     btn_q   <= BTN_DEP;
                     value_q <= word_data_i;
                     state_q <= DEPOSIT;
                  end else begin
                     btn_q   <= BTN_LPC;
                     value_q <= word_addr_i;
                     state_q <= WORD_LPC;
                  end
               end
            end
            WORD_LPC: begin
               if (op_done) begin
                  gap_q   <= GAP_LOAD;
                  state_q <= GAP;
               end
            end
            GAP: begin
               if (gap_q == '0) begin
                  go_q    <= 1'b1;
                  btn_q   <= BTN_DEP;
                  value_q <= data_q;
                  state_q <= DEPOSIT;
               end else begin
                  gap_q <= gap_q - 1'b1;
               end
            end
            DEPOSIT: begin
               if (op_done) begin
                  prev_q <= addr_q;
                  hist_q <= 1'b1;
                  if (last_q) begin
                     go_q    <= 1'b1;
                     btn_q   <= BTN_LPC;
                     value_q <= START_PC;
                     state_q <= FINAL_LPC;
                  end else begin
                     ready_q <= 1'b1;
                     state_q <= FETCH;
                  end
               end
            end
            FINAL_LPC: begin
               if (op_done) begin
                  run_q   <= 1'b1;
                  seen_q  <= 1'b0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               // The CPU must be seen running before a low LED means halted.
               if (run_led_i) begin
                  seen_q <= 1'b1;
               end else if (seen_q) begin
                  run_q    <= 1'b0;
                  halted_q <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= DONE;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign word_ready_o = ready_q;
   assign sw_o         = {run_q, sw_val};
   assign busy_o       = busy_q;
   assign halted_o     = halted_q;

endmodule
`default_nettype wire
